// File: rtl/pipeline_div_recombine.sv
// Rebuilds dividend = quotient * divisor + remainder with a QUOTIENT_WIDTH-deep shift-add pipeline.
// Define RECOMBINE_CHECK_EN to carry a remainder >= divisor flag alongside each operand set.
module pipeline_div_recombine #(
    parameter int unsigned QUOTIENT_WIDTH = 8,
    parameter int unsigned DIVISOR_WIDTH  = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [QUOTIENT_WIDTH-1:0]               quotient_i,
    input  logic [DIVISOR_WIDTH-1:0]                divisor_i,
    input  logic [DIVISOR_WIDTH-1:0]                reminder_i,
    input  logic                                    valid_i,
    output logic [QUOTIENT_WIDTH+DIVISOR_WIDTH-1:0] divinded_o,
    output logic                                    valid_o,
    output logic                                    range_err_o
);

    localparam int unsigned QW = QUOTIENT_WIDTH;
    localparam int unsigned DW = DIVISOR_WIDTH;
    localparam int unsigned OW = QW + DW;

    // Per-stage state: valid, running sum, and the operands later stages still need.
    logic          valid_q [QW];
    logic [OW-1:0] acc_q   [QW];
    logic [QW-1:0] quo_q   [QW];
    logic [DW-1:0] div_q   [QW];

    // Stage 1 seeds the sum with the remainder and folds in quotient bit 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q[0] <= 1'b0;
            acc_q[0]   <= '0;
            quo_q[0]   <= '0;
            div_q[0]   <= '0;
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                acc_q[0] <= OW'(reminder_i) + (quotient_i[0] ? OW'(divisor_i) : OW'(0));
                quo_q[0] <= quotient_i;
                div_q[0] <= divisor_i;
            end
        end
    end

    // Stage k+1 adds divisor << k when quotient bit k is set; data only moves with a valid.
    for (genvar k = 1; k < QW; k++) begin : g_stage
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q[k] <= 1'b0;
                acc_q[k]   <= '0;
                quo_q[k]   <= '0;
                div_q[k]   <= '0;
            end else begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    acc_q[k] <= acc_q[k-1]
                              + (quo_q[k-1][k] ? (OW'(div_q[k-1]) << k) : OW'(0));
                    quo_q[k] <= quo_q[k-1];
                    div_q[k] <= div_q[k-1];
                end
            end
        end
    end

    assign divinded_o = acc_q[QW-1];
    assign valid_o    = valid_q[QW-1];

`ifdef RECOMBINE_CHECK_EN
    logic err_q [QW];

    // Flag is decided once at entry and then simply rides along with its operand set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q[0] <= 1'b0;
        end else if (valid_i) begin
            err_q[0] <= (reminder_i >= divisor_i);
        end
    end

    for (genvar k = 1; k < QW; k++) begin : g_err
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                err_q[k] <= 1'b0;
            end else if (valid_q[k-1]) begin
                err_q[k] <= err_q[k-1];
            end
        end
    end

    assign range_err_o = err_q[QW-1];
`else
    assign range_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_div_recombine.sv
// Scoreboard bench for pipeline_div_recombine: directed cases plus randomized ops against q*d+r.
module tb_pipeline_div_recombine;

    localparam int unsigned QW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = QW + DW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [QW-1:0] quotient_i = '0;
    logic [DW-1:0] divisor_i = '0;
    logic [DW-1:0] reminder_i = '0;
    logic          valid_i = 1'b0;
    logic [OW-1:0] divinded_o;
    logic          valid_o;
    logic          range_err_o;

    pipeline_div_recombine #(
        .QUOTIENT_WIDTH(QW),
        .DIVISOR_WIDTH (DW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .quotient_i (quotient_i),
        .divisor_i  (divisor_i),
        .reminder_i (reminder_i),
        .valid_i    (valid_i),
        .divinded_o (divinded_o),
        .valid_o    (valid_o),
        .range_err_o(range_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] val;
        logic          err;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic          rst_d = 1'b1;
    logic [OW-1:0] last_val = '0;
    logic          last_err = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst_i;
    end

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_err(input logic [DW-1:0] d, input logic [DW-1:0] r);
`ifdef RECOMBINE_CHECK_EN
        return r >= d;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [OW-1:0] model(input logic [QW-1:0] q, input logic [DW-1:0] d,
                                            input logic [DW-1:0] r);
        int unsigned full;
        full = 32'(q) * 32'(d) + 32'(r);
        return OW'(full);
    endfunction

    // Monitor: pops one expectation per valid_o, checks latency, data, flag and hold behaviour.
    always @(negedge clk) begin
        if (rst_d) begin
            chk("reset_valid", OW'(valid_o), OW'(0));
            chk("reset_data", divinded_o, OW'(0));
            chk("reset_err", OW'(range_err_o), OW'(0));
            last_val = '0;
            last_err = 1'b0;
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("missing_result", OW'(0), sb[0].val);
                void'(sb.pop_front());
            end
            if (valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", OW'(valid_o), OW'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", OW'(cyc), OW'(e.due));
                    chk("dividend", divinded_o, e.val);
                    chk("range_err", OW'(range_err_o), OW'(e.err));
                    last_val = e.val;
                    last_err = e.err;
                end
            end else begin
                chk("valid_low", OW'(valid_o), OW'(0));
                chk("hold_data", divinded_o, last_val);
                chk("hold_err", OW'(range_err_o), OW'(last_err));
            end
        end
    end

    task automatic drive(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r,
                         input logic [OW-1:0] exp);
        exp_t e;
        quotient_i = q;
        divisor_i  = d;
        reminder_i = r;
        valid_i    = 1'b1;
        e.val = exp;
        e.err = exp_err(d, r);
        e.due = cyc + int'(QW);
        sb.push_back(e);
    endtask

    task automatic send(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r,
                        input logic [OW-1:0] exp);
        @(posedge clk);
        #1;
        drive(q, d, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_i    = 1'b0;
            quotient_i = QW'($urandom);
            divisor_i  = DW'($urandom);
            reminder_i = DW'($urandom);
        end
    endtask

    // Reset with valid_i held high: in-flight and offered operands must both vanish.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due > cyc) sb.delete(i);
        end
        valid_i    = 1'b1;
        quotient_i = QW'($urandom);
        divisor_i  = DW'($urandom);
        reminder_i = DW'($urandom);
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        logic [QW-1:0] q;
        logic [DW-1:0] d;
        logic [DW-1:0] r;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive(8'd25, 8'd10, 8'd3, 16'd253);
        idle(10);

        send(8'd255, 8'd255, 8'd254, 16'd65279);
        send(8'd0, 8'd0, 8'd0, 16'd0);
        idle(10);

        send(8'd3, 8'd4, 8'd1, 16'd13);
        send(8'd7, 8'd9, 8'd8, 16'd71);
        send(8'd200, 8'd100, 8'd99, 16'd20099);
        idle(12);

        send(8'd1, 8'd7, 8'd7, 16'd14);
        send(8'd9, 8'd0, 8'd5, 16'd5);
        idle(10);

        send(8'd77, 8'd33, 8'd12, 16'd2553);
        idle(2);
        do_reset(2);
        idle(10);
        send(8'd100, 8'd200, 8'd50, 16'd20050);
        idle(10);

        for (int i = 0; i < 1000; i++) begin
            q = QW'($urandom);
            d = DW'($urandom);
            r = DW'($urandom);
            case ($urandom_range(0, 15))
                0: d = '0;
                1: q = '1;
                2: r = '1;
                default: ;
            endcase
            send(q, d, r, model(q, d, r));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(1);
        for (int i = 0; i < 4 * int'(QW) && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            chk("drain_timeout", OW'(0), sb[0].val);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
